// File: rtl/block_mover.sv
// Bouncing block position generator: steps the block origin once per frame at vblank start.
// Optional macro BLOCK_MOVER_SPEEDUP_EN adds a per-bounce step increment and the step_out port.
module block_mover #(
    parameter int WIDTH    = 128,
    parameter int HEIGHT   = 128,
    parameter int SCREEN_W = 1280,
    parameter int SCREEN_H = 720,
    parameter int SPEED    = 4,
    parameter int START_X  = 0,
    parameter int START_Y  = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        start_in,
    input  logic        pause_in,
    input  logic        stop_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        bounce_out,
    output logic        corner_out,
    output logic        running_out
`ifdef BLOCK_MOVER_SPEEDUP_EN
    ,
    output logic [4:0]  step_out
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    localparam logic [11:0] X_MAX     = 12'(SCREEN_W - WIDTH);
    localparam logic [10:0] Y_MAX     = 11'(SCREEN_H - HEIGHT);
    localparam logic [10:0] X_HOME    = 11'(START_X);
    localparam logic [9:0]  Y_HOME    = 10'(START_Y);
    localparam logic [4:0]  STEP_INIT = 5'(SPEED);

    state_t      state_q;
    logic        fs_q;
    logic        fs_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        dx_q, dx_d;   // 1 = moving right
    logic        dy_q, dy_d;   // 1 = moving down
    logic        hit_x, hit_y;
    logic [11:0] x_sum;
    logic [10:0] y_sum;
    logic        bounce_q, corner_q, running_q;
    logic [4:0]  step;

`ifdef BLOCK_MOVER_SPEEDUP_EN
    logic [4:0]  step_q, step_d;
    assign step     = step_q;
    assign step_out = step_q;

    always_comb begin
        step_d = step_q;
        if ((hit_x || hit_y) && (step_q != 5'd31)) begin
            step_d = step_q + 5'd1;
        end
    end
`else
    assign step = STEP_INIT;
`endif

    // First vblank line start; registered so the strobe is a clean single cycle.
    assign fs_d = (hcount_in == 11'd0) && (vcount_in == 10'(SCREEN_H));

    // Candidate next position per axis; widened sums keep the wall compare wrap-free.
    always_comb begin
        x_sum = {1'b0, x_q} + {7'd0, step};
        x_d   = x_q;
        dx_d  = dx_q;
        hit_x = 1'b0;
        if (dx_q) begin
            if (x_sum >= X_MAX) begin
                x_d   = X_MAX[10:0];
                dx_d  = 1'b0;
                hit_x = 1'b1;
            end else begin
                x_d = x_sum[10:0];
            end
        end else if ({1'b0, x_q} <= {7'd0, step}) begin
            x_d   = '0;
            dx_d  = 1'b1;
            hit_x = 1'b1;
        end else begin
            x_d = x_q - {6'd0, step};
        end
    end

    always_comb begin
        y_sum = {1'b0, y_q} + {6'd0, step};
        y_d   = y_q;
        dy_d  = dy_q;
        hit_y = 1'b0;
        if (dy_q) begin
            if (y_sum >= Y_MAX) begin
                y_d   = Y_MAX[9:0];
                dy_d  = 1'b0;
                hit_y = 1'b1;
            end else begin
                y_d = y_sum[9:0];
            end
        end else if ({1'b0, y_q} <= {6'd0, step}) begin
            y_d   = '0;
            dy_d  = 1'b1;
            hit_y = 1'b1;
        end else begin
            y_d = y_q - {5'd0, step};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            fs_q      <= 1'b0;
            x_q       <= X_HOME;
            y_q       <= Y_HOME;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            bounce_q  <= 1'b0;
            corner_q  <= 1'b0;
            running_q <= 1'b0;
`ifdef BLOCK_MOVER_SPEEDUP_EN
            step_q    <= STEP_INIT;
`endif
        end else begin
            fs_q     <= fs_d;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
            if (stop_in) begin
                state_q   <= IDLE;
                running_q <= 1'b0;
                x_q       <= X_HOME;
                y_q       <= Y_HOME;
                dx_q      <= 1'b1;
                dy_q      <= 1'b1;
`ifdef BLOCK_MOVER_SPEEDUP_EN
                step_q    <= STEP_INIT;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_in) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        // A pause landing on the strobe cycle suppresses that frame's step.
                        if (pause_in) begin
                            state_q   <= PAUSED;
                            running_q <= 1'b0;
                        end else if (fs_q) begin
                            x_q      <= x_d;
                            y_q      <= y_d;
                            dx_q     <= dx_d;
                            dy_q     <= dy_d;
                            bounce_q <= hit_x | hit_y;
                            corner_q <= hit_x & hit_y;
`ifdef BLOCK_MOVER_SPEEDUP_EN
                            step_q   <= step_d;
`endif
                        end
                    end
                    PAUSED: begin
                        if (!pause_in) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign x_out       = x_q;
    assign y_out       = y_q;
    assign bounce_out  = bounce_q;
    assign corner_out  = corner_q;
    assign running_out = running_q;

endmodule

// File: tb/tb_block_mover.sv
// Bench for block_mover: three instances with different home positions share one stimulus
// stream and are checked every cycle against an integer reference model plus directed values.
module tb_block_mover;

    localparam int XMAX    = 1152;
    localparam int YMAX    = 592;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
`ifdef BLOCK_MOVER_SPEEDUP_EN
    localparam int STEP2 = 5;
`else
    localparam int STEP2 = 4;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        start_in, pause_in, stop_in;
    logic [10:0] x_o [3];
    logic [9:0]  y_o [3];
    logic        b_o [3];
    logic        c_o [3];
    logic        r_o [3];
`ifdef BLOCK_MOVER_SPEEDUP_EN
    logic [4:0]  s_o [3];
`endif

    int total = 0;
    int bad   = 0;

    int mx [3], my [3], mdx [3], mdy [3], mmode [3], mstep [3];
    bit mb [3], mc [3];
    bit mfs;
    int sx [3] = '{0, 1150, 1150};
    int sy [3] = '{0, 300, 590};

    always #5 clk_in = ~clk_in;

    block_mover u_dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .start_in(start_in), .pause_in(pause_in), .stop_in(stop_in),
        .x_out(x_o[0]), .y_out(y_o[0]), .bounce_out(b_o[0]), .corner_out(c_o[0]),
        .running_out(r_o[0])
`ifdef BLOCK_MOVER_SPEEDUP_EN
        , .step_out(s_o[0])
`endif
    );

    block_mover #(.START_X(1150), .START_Y(300)) u_dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .start_in(start_in), .pause_in(pause_in), .stop_in(stop_in),
        .x_out(x_o[1]), .y_out(y_o[1]), .bounce_out(b_o[1]), .corner_out(c_o[1]),
        .running_out(r_o[1])
`ifdef BLOCK_MOVER_SPEEDUP_EN
        , .step_out(s_o[1])
`endif
    );

    block_mover #(.START_X(1150), .START_Y(590)) u_dut2 (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .start_in(start_in), .pause_in(pause_in), .stop_in(stop_in),
        .x_out(x_o[2]), .y_out(y_o[2]), .bounce_out(b_o[2]), .corner_out(c_o[2]),
        .running_out(r_o[2])
`ifdef BLOCK_MOVER_SPEEDUP_EN
        , .step_out(s_o[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mfs = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mx[k] = sx[k]; my[k] = sy[k]; mdx[k] = 1; mdy[k] = 1;
            mmode[k] = M_IDLE; mstep[k] = 4; mb[k] = 1'b0; mc[k] = 1'b0;
        end
    endtask

    // One clock edge of the behaviour, from the rules: stop first, then mode, then motion.
    task automatic model_edge();
        bit fs_now, hx, hy;
        fs_now = mfs;
        mfs = (hcount_in == 0) && (vcount_in == 720);
        for (int k = 0; k < 3; k++) begin
            mb[k] = 1'b0; mc[k] = 1'b0;
            if (stop_in) begin
                mmode[k] = M_IDLE; mx[k] = sx[k]; my[k] = sy[k];
                mdx[k] = 1; mdy[k] = 1; mstep[k] = 4;
            end else if (mmode[k] == M_IDLE) begin
                if (start_in) mmode[k] = M_RUN;
            end else if (mmode[k] == M_PAUSE) begin
                if (!pause_in) mmode[k] = M_RUN;
            end else if (pause_in) begin
                mmode[k] = M_PAUSE;
            end else if (fs_now) begin
                hx = 1'b0; hy = 1'b0;
                if (mdx[k] > 0 && mx[k] + mstep[k] >= XMAX) begin mx[k] = XMAX; mdx[k] = -1; hx = 1'b1; end
                else if (mdx[k] < 0 && mx[k] - mstep[k] <= 0) begin mx[k] = 0; mdx[k] = 1; hx = 1'b1; end
                else mx[k] = mx[k] + mdx[k] * mstep[k];
                if (mdy[k] > 0 && my[k] + mstep[k] >= YMAX) begin my[k] = YMAX; mdy[k] = -1; hy = 1'b1; end
                else if (mdy[k] < 0 && my[k] - mstep[k] <= 0) begin my[k] = 0; mdy[k] = 1; hy = 1'b1; end
                else my[k] = my[k] + mdy[k] * mstep[k];
                mb[k] = hx | hy;
                mc[k] = hx & hy;
`ifdef BLOCK_MOVER_SPEEDUP_EN
                if (mb[k] && mstep[k] < 31) mstep[k] = mstep[k] + 1;
`endif
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("x%0d", k), x_o[k], mx[k]);
            chk($sformatf("y%0d", k), y_o[k], my[k]);
            chk($sformatf("bounce%0d", k), b_o[k], mb[k]);
            chk($sformatf("corner%0d", k), c_o[k], mc[k]);
            chk($sformatf("running%0d", k), r_o[k], mmode[k] == M_RUN);
            chk($sformatf("xlimit%0d", k), x_o[k] <= XMAX, 1);
            chk($sformatf("ylimit%0d", k), y_o[k] <= YMAX, 1);
`ifdef BLOCK_MOVER_SPEEDUP_EN
            chk($sformatf("step%0d", k), s_o[k], mstep[k]);
`endif
        end
    endtask

    task automatic check_home();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_x%0d", k), x_o[k], sx[k]);
            chk($sformatf("rst_y%0d", k), y_o[k], sy[k]);
            chk($sformatf("rst_bounce%0d", k), b_o[k], 0);
            chk($sformatf("rst_corner%0d", k), c_o[k], 0);
            chk($sformatf("rst_running%0d", k), r_o[k], 0);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_noise();
        hcount_in = 11'($urandom_range(0, 1649));
        vcount_in = 10'($urandom_range(0, 749));
        if (hcount_in == 0 && vcount_in == 720) hcount_in = 11'd1;
    endtask

    // Strobe cycle followed by gap ordinary cycles; with gap=1 the update edge is the last one.
    task automatic frame(input int gap);
        hcount_in = 11'd0;
        vcount_in = 10'd720;
        cyc();
        set_noise();
        repeat (gap) cyc();
    endtask

    initial begin
        rst_in = 1'b1; start_in = 1'b0; pause_in = 1'b0; stop_in = 1'b0;
        set_noise();
        model_reset();
        #12;
        check_home();
        @(negedge clk_in);
        rst_in = 1'b0;
        cyc();

        start_in = 1'b1; cyc(); start_in = 1'b0;
        chk("start_running", r_o[0], 1);

        frame(1);
        chk("f1_x0", x_o[0], 4);    chk("f1_y0", y_o[0], 4);   chk("f1_b0", b_o[0], 0);
        chk("f1_x1", x_o[1], 1152); chk("f1_y1", y_o[1], 304); chk("f1_b1", b_o[1], 1);
        chk("f1_c1", c_o[1], 0);
        chk("f1_x2", x_o[2], 1152); chk("f1_y2", y_o[2], 592); chk("f1_b2", b_o[2], 1);
        chk("f1_c2", c_o[2], 1);
        frame(1);
        chk("f2_x0", x_o[0], 8);    chk("f2_y0", y_o[0], 8);
        chk("f2_x1", x_o[1], 1152 - STEP2); chk("f2_y1", y_o[1], 304 + STEP2);
        chk("f2_x2", x_o[2], 1152 - STEP2); chk("f2_y2", y_o[2], 592 - STEP2);
        chk("f2_b1", b_o[1], 0);
        frame(3);
        chk("f3_x0", x_o[0], 12);   chk("f3_y0", y_o[0], 12);  chk("f3_b0", b_o[0], 0);

        pause_in = 1'b1; cyc();
        chk("pause_running", r_o[0], 0);
        frame(2); frame(2);
        chk("pause_x0", x_o[0], 12); chk("pause_y0", y_o[0], 12);
        pause_in = 1'b0; cyc();
        frame(1);
        chk("resume_x0", x_o[0], 16); chk("resume_y0", y_o[0], 16);

        hcount_in = 11'd0; vcount_in = 10'd720; cyc();
        pause_in = 1'b1; set_noise(); cyc();
        chk("pause_on_fs_x0", x_o[0], 16);
        pause_in = 1'b0; cyc();
        frame(1);
        chk("after_fs_pause_x0", x_o[0], 20);

        for (int i = 0; i < 100 && mx[0] != 200; i++) frame(1);
        chk("reach_x200", x_o[0], 200);
        cyc();
        stop_in = 1'b1; cyc(); stop_in = 1'b0;
        chk("stop_x0", x_o[0], 0); chk("stop_y0", y_o[0], 0); chk("stop_run0", r_o[0], 0);
        chk("stop_x1", x_o[1], 1150);
        frame(2);
        chk("idle_fs_x0", x_o[0], 0); chk("idle_fs_y0", y_o[0], 0);
        pause_in = 1'b1; cyc(); pause_in = 1'b0;
        chk("idle_pause_run", r_o[0], 0);

        start_in = 1'b1; cyc(); start_in = 1'b0;
        pause_in = 1'b1; cyc();
        start_in = 1'b1; cyc(); start_in = 1'b0;
        chk("paused_start_run", r_o[0], 0);
        pause_in = 1'b0; cyc();
        chk("unpause_run", r_o[0], 1);

        repeat (800) begin
            start_in = ($urandom % 8) == 0;
            pause_in = ($urandom % 6) == 0;
            stop_in  = ($urandom % 60) == 0;
            if (($urandom % 4) == 0) begin
                hcount_in = 11'd0; vcount_in = 10'd720;
            end else begin
                set_noise();
            end
            cyc();
        end
        start_in = 1'b0; pause_in = 1'b0; stop_in = 1'b0;
        set_noise();

        start_in = 1'b1; cyc(); start_in = 1'b0;
        hcount_in = 11'd0; vcount_in = 10'd720; cyc(); set_noise();
        @(posedge clk_in);
        model_edge();
        #3;
        rst_in = 1'b1;
        #1;
        model_reset();
        check_home();
        #2;
        rst_in = 1'b0;
        cyc();
        chk("post_rst_x0", x_o[0], 0);
        start_in = 1'b1; cyc(); start_in = 1'b0;
        frame(1);
        chk("post_rst_step_x0", x_o[0], 4); chk("post_rst_step_y0", y_o[0], 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
